// File: rtl/vdot_seq_ctrl_if.sv
// Operand-fetch bus between the VDOT sequencer (master) and the operand memory (slave).
// Both operand streams share a request handshake and return on the same beat.
interface vdot_seq_ctrl_if #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8
);
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [31:0]               mem_addr_a;
    logic [31:0]               mem_addr_b;
    logic                      mem_rvalid;
    logic [LANES*ELEM_W-1:0]   mem_rdata_a;
    logic [LANES*ELEM_W-1:0]   mem_rdata_b;

    modport master (
        output mem_req_valid, mem_addr_a, mem_addr_b,
        input  mem_req_ready, mem_rvalid, mem_rdata_a, mem_rdata_b
    );

    modport slave (
        input  mem_req_valid, mem_addr_a, mem_addr_b,
        output mem_req_ready, mem_rvalid, mem_rdata_a, mem_rdata_b
    );
endinterface

// File: rtl/vdot_seq_ctrl.sv
// VDOT sequencer: decodes VDOT, fetches LANES-wide operand beats and accumulates a dot product.
// Optional macro VDOT_SAT_EN makes every accumulation saturate instead of wrapping.
module vdot_seq_ctrl #(
    parameter int LANES  = 4,
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inst_valid,
    input  logic [31:0]            inst,
    input  logic [31:0]            rs1_val,
    input  logic [31:0]            rs2_val,
    vdot_seq_ctrl_if.master        mem,
    output logic                   stall,
    output logic                   busy,
    output logic                   wb_valid,
    output logic [4:0]             wb_rd,
    output logic [31:0]            wb_data,
    output logic                   illegal
);
    localparam logic [6:0]  OPC_VDOT = 7'b0101011;
    localparam logic [31:0] STEP     = 32'(LANES * ELEM_W / 8);
`ifdef VDOT_SAT_EN
    localparam int SUM_W = ACC_W + 8;
`else
    localparam int SUM_W = ACC_W;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_a_q, addr_a_d;
    logic [31:0]        addr_b_q, addr_b_d;
    logic [4:0]         rd_q, rd_d;
    logic               sgn_q, sgn_d;
    logic [6:0]         elem_left_q, elem_left_d;
    logic [7:0]         beats_left_q, beats_left_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               req_valid_q, req_valid_d;
    logic               busy_q, busy_d;
    logic               wb_valid_q, wb_valid_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;

    logic               idle_vdot;
    logic               accept;
    logic [SUM_W-1:0]   beat_sum;
    logic [ACC_W-1:0]   acc_next;
    logic               unused_inst;

    function automatic logic [SUM_W-1:0] extend(input logic [ELEM_W-1:0] e, input logic sgn);
        return {{(SUM_W-ELEM_W){sgn & e[ELEM_W-1]}}, e};
    endfunction

    assign idle_vdot   = rst_n && inst_valid && (inst[6:0] == OPC_VDOT) && (state_q == IDLE);
    assign accept      = idle_vdot && (inst[14:12] <= 3'd1);
    assign illegal     = idle_vdot && (inst[14:12] > 3'd1);
    assign stall       = accept || (state_q != IDLE);
    assign unused_inst = ^inst[24:15];

    // Lanes at or beyond the remaining element count belong past the vector end and add nothing.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(elem_left_q)) begin
                beat_sum = beat_sum + extend(mem.mem_rdata_a[i*ELEM_W +: ELEM_W], sgn_q)
                                    * extend(mem.mem_rdata_b[i*ELEM_W +: ELEM_W], sgn_q);
            end
        end
    end

`ifdef VDOT_SAT_EN
    localparam logic [SUM_W-1:0] S_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic [SUM_W-1:0] S_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic [SUM_W-1:0] U_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
    logic [SUM_W-1:0] wide_sum;

    // Guard bits hold the exact beat total so the clamp sees the true result.
    always_comb begin
        wide_sum = {{(SUM_W-ACC_W){sgn_q & acc_q[ACC_W-1]}}, acc_q} + beat_sum;
        acc_next = wide_sum[ACC_W-1:0];
        if (sgn_q) begin
            if ($signed(wide_sum) > $signed(S_MAX)) begin
                acc_next = S_MAX[ACC_W-1:0];
            end else if ($signed(wide_sum) < $signed(S_MIN)) begin
                acc_next = S_MIN[ACC_W-1:0];
            end
        end else if (wide_sum > U_MAX) begin
            acc_next = U_MAX[ACC_W-1:0];
        end
    end
`else
    assign acc_next = acc_q + beat_sum;
`endif

    always_comb begin
        state_d      = state_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        rd_d         = rd_q;
        sgn_d        = sgn_q;
        elem_left_d  = elem_left_q;
        beats_left_d = beats_left_q;
        acc_d        = acc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_a_d     = rs1_val;
                    addr_b_d     = rs2_val;
                    rd_d         = inst[11:7];
                    sgn_d        = ~inst[12];
                    elem_left_d  = inst[31:25];
                    beats_left_d = ({1'b0, inst[31:25]} + 8'(LANES - 1)) / 8'(LANES);
                    acc_d        = '0;
                    state_d      = (inst[31:25] == 7'd0) ? WB : REQ;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    addr_a_d = addr_a_q + STEP;
                    addr_b_d = addr_b_q + STEP;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    acc_d        = acc_next;
                    beats_left_d = beats_left_q - 8'd1;
                    elem_left_d  = (elem_left_q > 7'(LANES)) ? elem_left_q - 7'(LANES) : 7'd0;
                    state_d      = (beats_left_q == 8'd1) ? WB : REQ;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        req_valid_d = (state_d == REQ);
        busy_d      = (state_d != IDLE);
        wb_valid_d  = (state_d == WB);
        wb_rd_d     = (state_d == WB) ? rd_d : 5'd0;
        wb_data_d   = (state_d == WB) ? acc_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            rd_q         <= '0;
            sgn_q        <= 1'b0;
            elem_left_q  <= '0;
            beats_left_q <= '0;
            acc_q        <= '0;
            req_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            rd_q         <= rd_d;
            sgn_q        <= sgn_d;
            elem_left_q  <= elem_left_d;
            beats_left_q <= beats_left_d;
            acc_q        <= acc_d;
            req_valid_q  <= req_valid_d;
            busy_q       <= busy_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_addr_a    = addr_a_q;
    assign mem.mem_addr_b    = addr_b_q;
    assign busy              = busy_q;
    assign wb_valid          = wb_valid_q;
    assign wb_rd             = wb_rd_q;
    assign wb_data           = wb_data_q;
endmodule

// File: tb/tb_vdot_seq_ctrl.sv
// Randomised bench for vdot_seq_ctrl: a byte-memory responder feeds beats and a plain
// element-by-element dot-product model supplies the expected writeback.
module tb_vdot_seq_ctrl;
    localparam int          LANES  = 4;
    localparam int          ELEM_W = 8;
    localparam int          DW     = LANES * ELEM_W;
    localparam logic [31:0] STEP   = 32'(LANES * ELEM_W / 8);
    localparam logic [6:0]  OPC    = 7'b0101011;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        stall, busy, wb_valid, illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic        w_stall, w_busy, w_wb_valid, w_illegal;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_data;

    logic [7:0]  memA [256];
    logic [7:0]  memB [256];
    int          vecCount;
    int          missCount;

    vdot_seq_ctrl_if #(.LANES(LANES), .ELEM_W(ELEM_W)) mem_bus ();
    vdot_seq_ctrl_if #(.LANES(4), .ELEM_W(16)) wide_bus ();

    vdot_seq_ctrl #(.LANES(LANES), .ELEM_W(ELEM_W), .ACC_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .mem(mem_bus),
        .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .illegal(illegal)
    );

    vdot_seq_ctrl #(.LANES(4), .ELEM_W(16), .ACC_W(32)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .inst_valid(w_inst_valid), .inst(w_inst),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .mem(wide_bus),
        .stall(w_stall), .busy(w_busy), .wb_valid(w_wb_valid), .wb_rd(w_wb_rd),
        .wb_data(w_wb_data), .illegal(w_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic fillMemory();
        for (int i = 0; i < 256; i++) begin
            memA[i] = 8'($urandom);
            memB[i] = 8'($urandom);
        end
    endtask

    // Reference: sum over elements 0..n-1 of the extended byte products, 32-bit result.
    function automatic logic [31:0] modelDot(input logic sgn, input int n,
                                             input logic [31:0] ba, input logic [31:0] bb);
        longint acc;
        int     av, bv;
        logic [7:0] ea, eb;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            ea  = memA[8'(ba + 32'(k))];
            eb  = memB[8'(bb + 32'(k))];
            av  = sgn ? int'($signed(ea)) : int'(ea);
            bv  = sgn ? int'($signed(eb)) : int'(eb);
            acc = acc + longint'(av * bv);
`ifdef VDOT_SAT_EN
            if (sgn && acc > 64'sd2147483647) acc = 64'sd2147483647;
            if (sgn && acc < -64'sd2147483648) acc = -64'sd2147483648;
            if (!sgn && acc > 64'sd4294967295) acc = 64'sd4294967295;
`endif
        end
        return acc[31:0];
    endfunction

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_req"}, 32'(mem_bus.mem_req_valid), 32'd0);
        checkOutput({tag, "_addr_a"}, mem_bus.mem_addr_a, 32'd0);
        checkOutput({tag, "_addr_b"}, mem_bus.mem_addr_b, 32'd0);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        checkOutput({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        checkOutput({tag, "_wb_data"}, wb_data, 32'd0);
        checkOutput({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    // One VDOT: the bench acts as memory, holding ready low rdyLat cycles and rvalid low rvLat cycles.
    task automatic applyStimulus(input logic [2:0] f3, input int n, input logic [4:0] rd,
                                 input logic [31:0] ba, input logic [31:0] bb,
                                 input int rdyLat, input int rvLat, output logic [31:0] gotData);
        int beats, beat, phase, waitCnt, expCyc;
        logic done;
        logic [31:0] expData, addr;
        beats   = (n + LANES - 1) / LANES;
        expData = modelDot(~f3[0], n, ba, bb);
        expCyc  = 1 + beats * (rdyLat + rvLat + 2);
        gotData = '0;
        beat = 0; phase = 0; waitCnt = 0; done = 1'b0;
        @(negedge clk);
        rs1_val = ba; rs2_val = bb;
        inst_valid = 1'b1;
        inst = {7'(n), 10'($urandom), f3, rd, OPC};
        #1;
        checkOutput("accept_stall", 32'(stall), 32'd1);
        checkOutput("accept_illegal", 32'(illegal), 32'd0);
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(negedge clk);
            inst_valid = 1'($urandom);
            inst = $urandom;
            if ($urandom_range(0, 1) == 1) inst[6:0] = OPC;
            mem_bus.mem_req_ready = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata_a = DW'($urandom);
            mem_bus.mem_rdata_b = DW'($urandom);
            if (wb_valid) begin
                checkOutput("wb_cycle", 32'(cyc), 32'(expCyc));
                checkOutput("wb_rd", 32'(wb_rd), 32'(rd));
                checkOutput("wb_data", wb_data, expData);
                checkOutput("wb_req_low", 32'(mem_bus.mem_req_valid), 32'd0);
                gotData = wb_data;
                mem_bus.mem_rvalid = 1'($urandom);
                done = 1'b1;
            end else if (phase == 0) begin
                checkOutput("req_valid", 32'(mem_bus.mem_req_valid), 32'd1);
                checkOutput("addr_a", mem_bus.mem_addr_a, ba + 32'(beat) * STEP);
                checkOutput("addr_b", mem_bus.mem_addr_b, bb + 32'(beat) * STEP);
                mem_bus.mem_rvalid = 1'($urandom);
                if (waitCnt < rdyLat) begin
                    waitCnt++;
                end else begin
                    mem_bus.mem_req_ready = 1'b1;
                    waitCnt = 0;
                    phase = 1;
                end
            end else begin
                checkOutput("req_dropped", 32'(mem_bus.mem_req_valid), 32'd0);
                if (waitCnt < rvLat) begin
                    waitCnt++;
                end else begin
                    addr = ba + 32'(beat) * STEP;
                    for (int i = 0; i < LANES; i++) begin
                        mem_bus.mem_rdata_a[i*ELEM_W +: ELEM_W] = memA[8'(addr + 32'(i))];
                        mem_bus.mem_rdata_b[i*ELEM_W +: ELEM_W] = memB[8'(bb + 32'(beat) * STEP + 32'(i))];
                    end
                    mem_bus.mem_rvalid = 1'b1;
                    beat++;
                    waitCnt = 0;
                    phase = 0;
                end
            end
            #1;
            checkOutput("busy_held", 32'(busy), 32'd1);
            checkOutput("stall_held", 32'(stall), 32'd1);
            checkOutput("busy_illegal", 32'(illegal), 32'd0);
        end
        if (!done) checkOutput("wb_timeout", 32'd0, 32'd1);
        @(negedge clk);
        inst_valid = 1'b0;
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        #1;
        checkOutput("post_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("post_busy", 32'(busy), 32'd0);
        checkOutput("post_stall", 32'(stall), 32'd0);
    endtask

    task automatic checkIllegal(input logic [2:0] f3);
        @(negedge clk);
        inst_valid = 1'b1;
        inst = {7'd4, 10'($urandom), f3, 5'd3, OPC};
        #1;
        checkOutput("illegal_pulse", 32'(illegal), 32'd1);
        checkOutput("illegal_stall", 32'(stall), 32'd0);
        @(negedge clk);
        inst = {25'($urandom), 7'b0110011};
        #1;
        checkOutput("other_op_illegal", 32'(illegal), 32'd0);
        checkOutput("other_op_stall", 32'(stall), 32'd0);
        checkOutput("illegal_no_busy", 32'(busy), 32'd0);
        @(negedge clk);
        inst_valid = 1'b0;
        #1;
        checkOutput("illegal_no_req", 32'(mem_bus.mem_req_valid), 32'd0);
        checkOutput("illegal_no_wb", 32'(wb_valid), 32'd0);
    endtask

    task automatic abortInWait();
        fillMemory();
        @(negedge clk);
        rs1_val = 32'h40; rs2_val = 32'h80;
        inst_valid = 1'b1;
        inst = {7'd8, 10'd0, 3'd0, 5'd7, OPC};
        @(negedge clk);
        inst_valid = 1'b0;
        checkOutput("abort_req", 32'(mem_bus.mem_req_valid), 32'd1);
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_bus.mem_req_ready = 1'b0;
        checkOutput("abort_wait_busy", 32'(busy), 32'd1);
        checkOutput("abort_wait_req", 32'(mem_bus.mem_req_valid), 32'd0);
        rst_n = 1'b0;
        mem_bus.mem_rvalid = 1'b1;
        #1;
        checkIdleOutputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        mem_bus.mem_rvalid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("abort_no_wb", 32'(wb_valid), 32'd0);
            checkOutput("abort_idle", 32'(busy), 32'd0);
        end
    endtask

    // 16-bit elements: expected total is four products of 0x7FFF squared.
    task automatic runWide();
        longint expSum;
        logic [31:0] expW;
        logic seen;
        expSum = 4 * (longint'(32767) * 32767);
`ifdef VDOT_SAT_EN
        if (expSum > 64'sd2147483647) expSum = 64'sd2147483647;
`endif
        expW = expSum[31:0];
        wide_bus.mem_req_ready = 1'b1;
        wide_bus.mem_rvalid = 1'b1;
        wide_bus.mem_rdata_a = {4{16'h7FFF}};
        wide_bus.mem_rdata_b = {4{16'h7FFF}};
        @(negedge clk);
        rs1_val = 32'h200; rs2_val = 32'h300;
        w_inst_valid = 1'b1;
        w_inst = {7'd4, 10'd0, 3'd0, 5'd5, OPC};
        @(negedge clk);
        w_inst_valid = 1'b0;
        checkOutput("w16_req", 32'(wide_bus.mem_req_valid), 32'd1);
        checkOutput("w16_addr_a", wide_bus.mem_addr_a, 32'h200);
        checkOutput("w16_addr_b", wide_bus.mem_addr_b, 32'h300);
        checkOutput("w16_stall", 32'(w_stall), 32'd1);
        checkOutput("w16_busy", 32'(w_busy), 32'd1);
        checkOutput("w16_illegal", 32'(w_illegal), 32'd0);
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (w_wb_valid) begin
                seen = 1'b1;
                checkOutput("w16_cycle", 32'(c), 32'd3);
                checkOutput("w16_rd", 32'(w_wb_rd), 32'd5);
                checkOutput("w16_data", w_wb_data, expW);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) checkOutput("w16_timeout", 32'd0, 32'd1);
        wide_bus.mem_req_ready = 1'b0;
        wide_bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        int n;
        vecCount = 0;
        missCount = 0;
        rst_n = 1'b0;
        inst_valid = 1'b0; inst = '0; rs1_val = '0; rs2_val = '0;
        w_inst_valid = 1'b0; w_inst = '0;
        mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata_a = '0; mem_bus.mem_rdata_b = '0;
        wide_bus.mem_req_ready = 1'b0; wide_bus.mem_rvalid = 1'b0;
        wide_bus.mem_rdata_a = '0; wide_bus.mem_rdata_b = '0;
        repeat (2) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        fillMemory();
        memA[8'h00] = 8'd1; memA[8'h01] = 8'd2; memA[8'h02] = 8'd3; memA[8'h03] = 8'd4;
        memB[8'h80] = 8'd5; memB[8'h81] = 8'd6; memB[8'h82] = 8'd7; memB[8'h83] = 8'd8;
        applyStimulus(3'd0, 4, 5'd9, 32'h0, 32'h80, 0, 0, got);
        checkOutput("basic_dot", got, 32'd70);

        fillMemory();
        memA[8'h00] = 8'hFF; memA[8'h01] = 8'hFE; memA[8'h02] = 8'h03; memA[8'h03] = 8'h04;
        memA[8'h04] = 8'h05; memA[8'h05] = 8'h06; memA[8'h06] = 8'h7F; memA[8'h07] = 8'h7F;
        memB[8'h40] = 8'h02; memB[8'h41] = 8'h02; memB[8'h42] = 8'h02; memB[8'h43] = 8'h02;
        memB[8'h44] = 8'h01; memB[8'h45] = 8'h01; memB[8'h46] = 8'h7F; memB[8'h47] = 8'h7F;
        applyStimulus(3'd0, 6, 5'd2, 32'h100, 32'h40, 0, 0, got);
        checkOutput("masked_tail", got, 32'd19);

        for (int i = 0; i < 4; i++) begin
            memA[8'h10 + 8'(i)] = 8'hFF;
            memB[8'h20 + 8'(i)] = 8'hFF;
        end
        applyStimulus(3'd1, 4, 5'd4, 32'h10, 32'h20, 0, 0, got);
        checkOutput("unsigned_ff", got, 32'd260100);
        applyStimulus(3'd0, 4, 5'd4, 32'h10, 32'h20, 0, 0, got);
        checkOutput("signed_ff", got, 32'd4);

        applyStimulus(3'd0, 0, 5'd11, 32'h10, 32'h20, 0, 0, got);
        checkOutput("zero_len", got, 32'd0);
        checkIllegal(3'd2);
        checkIllegal(3'd7);

        applyStimulus(3'd0, 7, 5'd12, 32'hFFFF_FFFC, 32'h33, 3, 1, got);
        abortInWait();

        for (int it = 0; it < 30; it++) begin
            fillMemory();
            n = (it == 0) ? 127 : int'($urandom_range(0, 19));
            applyStimulus(3'($urandom_range(0, 1)), n, 5'($urandom), $urandom, $urandom,
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), got);
        end

        runWide();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/vdot_seq_ctrl.md
VDOT_SEQ_CTRL -- requirements
Module: vdot_seq_ctrl

Interface
REQ-001 SHALL provide parameter LANES, default 4, elements fetched per operand per beat (1..8).
REQ-002 SHALL provide parameter ELEM_W, default 8, element width in bits (8 or 16).
REQ-003 SHALL provide parameter ACC_W, default 32, accumulator width in bits (32 only in this generation).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising-edge clock), rst_n input 1 (async active-low reset).
REQ-005 SHALL have these ports:
- inst_valid input 1: inst is presented for decode.
- inst input 32: instruction word.
- rs1_val input 32: operand A base byte address.
- rs2_val input 32: operand B base byte address.
- mem_req_valid output 1: beat read request.
- mem_req_ready input 1: request accepted.
- mem_addr_a output 32: A beat address.
- mem_addr_b output 32: B beat address.
- mem_rvalid input 1: beat read data valid.
- mem_rdata_a input LANES*ELEM_W: A lanes, lane 0 in the LSBs.
- mem_rdata_b input LANES*ELEM_W: B lanes, lane 0 in the LSBs.
- stall output 1: freeze the pipeline front-end.
- busy output 1: FSM not in IDLE.
- wb_valid output 1: register writeback pulse.
- wb_rd output 5: destination register.
- wb_data output 32: dot-product result.
- illegal output 1: malformed VDOT pulse.

Function
REQ-006 SHALL decode VDOT as inst_valid & inst[6:0]==7'b0101011; funct3 0 means signed elements, funct3 1 means unsigned elements.
REQ-007 SHALL pulse illegal for one cycle when opcode 0101011 arrives with funct3 greater than 1 in IDLE; no state change and no writeback follow.
REQ-008 SHALL take element count N from inst[31:25] (0..127), rd from inst[11:7], and beats from ceil(N/LANES).
REQ-009 SHALL use FSM states IDLE, REQ, WAIT and WB; reset enters IDLE.
REQ-010 SHALL sample a legal VDOT in IDLE, latching rs1_val, rs2_val, rd, mode, N and beats, and clearing the accumulator. It goes to REQ if N>0, else to WB.
REQ-011 SHALL, in REQ, hold mem_req_valid=1 with mem_addr_a and mem_addr_b stable until mem_req_ready=1, then go to WAIT.
REQ-012 SHALL, in WAIT, ignore cycles without mem_rvalid. On mem_rvalid it SHALL add the sum of a[i]*b[i] for active lanes to the accumulator, then go to REQ if beats remain, else to WB.
REQ-013 SHALL treat lanes with index >= N-(beat*LANES) on the final beat as masked and contributing 0, whatever the data.
REQ-014 SHALL advance both addresses by LANES*ELEM_W/8 bytes per accepted request, wrapping mod 2^32.
REQ-015 SHALL sign-extend or zero-extend elements per mode before multiplying; products and sums SHALL use ACC_W bits, wrapping mod 2^ACC_W by default.
REQ-016 SHALL, in WB, drive wb_valid=1, wb_rd and wb_data=accumulator for exactly one cycle, then return to IDLE.
REQ-017 SHALL assert stall combinationally in the IDLE cycle that accepts a VDOT, and in every non-IDLE cycle including WB.
REQ-018 SHALL ignore inst_valid while busy; no queueing.
REQ-019 SHALL, with mem_req_ready and mem_rvalid each high one cycle after their request, deliver wb_valid at T0+1+2*beats, where T0 is the accept cycle; for N=0, at T0+1.
REQ-020 SHALL give mem_rvalid no effect in IDLE, REQ or WB.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-operation, immediately force IDLE, the accumulator, the latched fields and all outputs to 0. The aborted instruction SHALL produce no wb_valid.
REQ-022 SHALL release from reset into IDLE, ready to accept an instruction on the first rising edge with rst_n high.

Configuration
REQ-023 SHALL, when VDOT_SAT_EN is defined, saturate each accumulation. Signed mode clamps to [0x80000000, 0x7FFFFFFF]; unsigned mode clamps to 0xFFFFFFFF.
REQ-024 SHALL, when VDOT_SAT_EN is undefined, wrap mod 2^ACC_W with no saturation logic present.

Verification
REQ-025 SHALL cover: LANES=4, signed, N=4, A={1,2,3,4}, B={5,6,7,8}, rd=9, zero-wait memory -> one request, wb_valid at T0+3, wb_rd=9, wb_data=70.
REQ-026 SHALL cover: signed, N=6, A={-1,-2,3,4,5,6,0x7F,0x7F}, B={2,2,2,2,1,1,0x7F,0x7F}, rs1=0x100 -> addresses 0x100 then 0x104, masked lanes ignored, wb_data=19.
REQ-027 SHALL cover: unsigned (funct3=1), N=4, all elements 0xFF -> wb_data=260100; same data in signed mode -> wb_data=4.
REQ-028 SHALL cover: N=0 -> no mem_req_valid, wb_valid at T0+1, wb_data=0; funct3=2 -> illegal pulse only, stall low.
REQ-029 SHALL cover: mem_req_ready low for 3 cycles -> mem_req_valid and addresses held stable, stall held; rst_n low during WAIT -> all outputs 0 next cycle and no wb_valid.
REQ-030 SHALL cover: ELEM_W=16, signed, N=4, all elements 0x7FFF -> wb_data=0xFFFC0004 without VDOT_SAT_EN, 0x7FFFFFFF with it.
